vga_capture: RTL and testbench
==============================

// Module: vga_capture
// PURPOSE
//  VGA sink: decodes hsync/vsync/rgb from the game's video path back into pixel
//  coordinates and RGB samples, measures line/frame timing, and declares lock.
//  Used as on-chip loopback checker and as the bench monitor for the video path.
//  Inputs are in the clk domain; no input synchronisers.
// PARAMETERS
//  H_DISPLAY   640  active pixels per line
//  H_SYNC      96   hsync pulse width (pixel ticks)
//  H_BACK      48   h back porch
//  H_TOTAL     800  expected pixel ticks per line
//  V_DISPLAY   480  active lines
//  V_SYNC      2    vsync width (lines)
//  V_BACK      33   v back porch (lines)
//  V_TOTAL     525  expected lines per frame
//  RGB_SKEW    1    pixel ticks rgb lags the syncs (source registers rgb)
//  LOCK_FRAMES 2    consecutive good frames needed to lock
// PORTS
//  clk          in   1   system clock
//  reset        in   1   synchronous, active-low reset
//  p_tick       in   1   pixel enable; all inputs sampled only when high
//  hsync        in   1   active-low horizontal sync
//  vsync        in   1   active-low vertical sync
//  rgb          in   3   pixel colour
//  pix_valid    out  1   1-clk strobe: active pixel captured
//  pixel_x      out  11  captured pixel column (0..H_DISPLAY-1)
//  pixel_y      out  11  captured pixel row (0..V_DISPLAY-1)
//  pix_rgb      out  3   captured colour
//  frame_start  out  1   1-clk strobe on each vsync falling edge
//  locked       out  1   timing locked
//  timing_err   out  1   sticky: any h/v measurement mismatch since reset
//  h_total_meas out  11  ticks between last two hsync falls
//  v_total_meas out  11  hsync falls in last complete frame
// BEHAVIOUR
//  - Reset (reset==0 at clk edge): all outputs 0, counters 0, state SEARCH,
//    hs_seen=0. Reset mid-frame aborts capture; relock needs LOCK_FRAMES+1 vsyncs.
//  - Edge detect on p_tick: hs_fall = prev hsync 1 & hsync 0; same for vs_fall.
//  - h_cnt: on hs_fall <= 0, else +1, saturating at 2047. On hs_fall with hs_seen:
//    h_total_meas <= h_cnt+1; mismatch vs H_TOTAL sets frame_bad, timing_err.
//  - v_cnt: on vs_fall <= 0 (wins over hs_fall); else on hs_fall +1.
//    On vs_fall: v_total_meas <= v_cnt + hs_fall; frame_start pulses.
//  - Active window: A = H_SYNC+H_BACK+RGB_SKEW, B = V_SYNC+V_BACK;
//    h_cnt in [A, A+H_DISPLAY-1] and v_cnt in [B, B+V_DISPLAY-1] and locked:
//    pix_valid=1, pixel_x=h_cnt-A, pixel_y=v_cnt-B, pix_rgb=rgb. Outputs are
//    registered: 1 clk after the sampling p_tick; x/y/rgb hold between strobes.
//  - FSM: SEARCH -(vs_fall)-> TRAIN (good=0, frame_bad=0).
//    TRAIN on vs_fall: frame ok (v_total_meas==V_TOTAL, !frame_bad) -> good+1,
//    else good=0; good reaching LOCK_FRAMES -> LOCKED. frame_bad cleared each vs_fall.
//    LOCKED on any mismatch (h at hs_fall, v at vs_fall) -> TRAIN, good=0,
//    locked drops next clk. locked=1 only in LOCKED.
//  - Loss: h_cnt saturating at 2047 in any state -> SEARCH, hs_seen=0, timing_err=1.
//  - Simultaneous hs_fall+vs_fall: h measured normally, v_cnt<=0, coincident
//    hsync counted into v_total_meas.
//  - p_tick low: no state change except strobes returning to 0.
// TESTING
//  1 reset low 3 clks mid-stream -> all outputs 0, locked 0, timing_err 0.
//  2 nominal 800x525 source (p_tick every 4th clk) -> h_total_meas=800,
//    v_total_meas=525, locked=1 one clk after 3rd vs_fall, timing_err=0.
//  3 locked, source rgb=x[2:0] -> every strobe pix_rgb==pixel_x[2:0];
//    exactly 640*480=307200 strobes/frame, first (0,0), last (639,479).
//  4 locked, one line stretched to 801 ticks -> h_total_meas=801, locked falls,
//    timing_err=1; clean frames relock after 2 more ok vs_falls.
//  5 hsync held high 2048 ticks -> state SEARCH, locked=0, timing_err=1.
//  6 frame with 526 lines -> v_total_meas=526, good reset, no lock that frame.

Source files
------------

// File: rtl/vga_capture.sv
// vga_capture: VGA sink that turns hsync/vsync/rgb back into pixel
// coordinates and colour, measures line/frame timing and reports lock.
module vga_capture #(
    parameter int H_DISPLAY   = 640,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int H_TOTAL     = 800,
    parameter int V_DISPLAY   = 480,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter int V_TOTAL     = 525,
    parameter int RGB_SKEW    = 1,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_tick,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [2:0]  rgb,
    output logic        pix_valid,
    output logic [10:0] pixel_x,
    output logic [10:0] pixel_y,
    output logic [2:0]  pix_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic        timing_err,
    output logic [10:0] h_total_meas,
    output logic [10:0] v_total_meas
);
    localparam logic [10:0] CNT_MAX = 11'h7ff;
    localparam logic [10:0] H_TOT   = 11'(H_TOTAL);
    localparam logic [10:0] V_TOT   = 11'(V_TOTAL);
    localparam logic [10:0] H_FIRST = 11'(H_SYNC + H_BACK + RGB_SKEW);
    localparam logic [10:0] H_LAST  = 11'(H_SYNC + H_BACK + RGB_SKEW + H_DISPLAY - 1);
    localparam logic [10:0] V_FIRST = 11'(V_SYNC + V_BACK);
    localparam logic [10:0] V_LAST  = 11'(V_SYNC + V_BACK + V_DISPLAY - 1);
    localparam logic [7:0]  GOOD_LAST = 8'(LOCK_FRAMES - 1);

    typedef enum logic [1:0] {SEARCH, TRAIN, LOCKED} state_t;

    state_t      state;
    logic        hs_prev;
    logic        vs_prev;
    logic        hs_seen;
    logic        frame_bad;
    logic [10:0] h_cnt;
    logic [10:0] v_cnt;
    logic [7:0]  good;

    logic        hs_fall;
    logic        vs_fall;
    logic        h_bad;
    logic        v_bad;
    logic        loss;
    logic        frame_ok;
    logic        in_window;
    logic [10:0] h_next;
    logic [10:0] v_next;
    logic [10:0] h_meas;
    logic [10:0] v_meas;

    // Counters are evaluated at their post-tick value so the window
    // compares the position of the sample being taken right now.
    always_comb begin
        hs_fall = hs_prev & ~hsync;
        vs_fall = vs_prev & ~vsync;
        h_meas  = h_cnt + 11'd1;
        v_meas  = v_cnt + {10'd0, hs_fall};
        if (hs_fall)
            h_next = '0;
        else if (h_cnt == CNT_MAX)
            h_next = CNT_MAX;
        else
            h_next = h_cnt + 11'd1;
        if (vs_fall)
            v_next = '0;
        else if (hs_fall && v_cnt != CNT_MAX)
            v_next = v_cnt + 11'd1;
        else
            v_next = v_cnt;
        loss      = (h_next == CNT_MAX);
        h_bad     = hs_fall & hs_seen & (h_meas != H_TOT);
        v_bad     = vs_fall & (state != SEARCH) & (v_meas != V_TOT);
        frame_ok  = (v_meas == V_TOT) & ~frame_bad & ~h_bad;
        in_window = (h_next >= H_FIRST) && (h_next <= H_LAST) &&
                    (v_next >= V_FIRST) && (v_next <= V_LAST);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= SEARCH;
            hs_prev      <= 1'b0;
            vs_prev      <= 1'b0;
            hs_seen      <= 1'b0;
            frame_bad    <= 1'b0;
            h_cnt        <= '0;
            v_cnt        <= '0;
            good         <= '0;
            pix_valid    <= 1'b0;
            pixel_x      <= '0;
            pixel_y      <= '0;
            pix_rgb      <= '0;
            frame_start  <= 1'b0;
            locked       <= 1'b0;
            timing_err   <= 1'b0;
            h_total_meas <= '0;
            v_total_meas <= '0;
        end else begin
            pix_valid   <= 1'b0;
            frame_start <= 1'b0;
            if (p_tick) begin
                hs_prev     <= hsync;
                vs_prev     <= vsync;
                h_cnt       <= h_next;
                v_cnt       <= v_next;
                frame_start <= vs_fall;
                if (in_window && state == LOCKED) begin
                    pix_valid <= 1'b1;
                    pixel_x   <= h_next - H_FIRST;
                    pixel_y   <= v_next - V_FIRST;
                    pix_rgb   <= rgb;
                end
                if (hs_fall) begin
                    hs_seen <= 1'b1;
                    if (hs_seen)
                        h_total_meas <= h_meas;
                end
                if (vs_fall)
                    v_total_meas <= v_meas;
                if (h_bad || v_bad || loss)
                    timing_err <= 1'b1;
                // A line that never ends means the source is gone.
                if (loss) begin
                    state   <= SEARCH;
                    locked  <= 1'b0;
                    good    <= '0;
                    hs_seen <= 1'b0;
                end else if (vs_fall) begin
                    frame_bad <= 1'b0;
                    unique case (state)
                        SEARCH: begin
                            state <= TRAIN;
                            good  <= '0;
                        end
                        TRAIN: begin
                            if (!frame_ok) begin
                                good <= '0;
                            end else if (good == GOOD_LAST) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end else begin
                                good <= good + 8'd1;
                            end
                        end
                        LOCKED: begin
                            if (!frame_ok) begin
                                state  <= TRAIN;
                                locked <= 1'b0;
                                good   <= '0;
                            end
                        end
                        default: begin
                            state  <= SEARCH;
                            locked <= 1'b0;
                        end
                    endcase
                end else if (h_bad) begin
                    frame_bad <= 1'b1;
                    if (state == LOCKED) begin
                        state  <= TRAIN;
                        locked <= 1'b0;
                        good   <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_vga_capture.sv
// Bench for vga_capture on a shrunken 16x10 raster: a table of whole frames
// plus reset/loss sequences, checked against a tick-timestamp model.
module tb_vga_capture;
    localparam int HD = 8;
    localparam int HS = 3;
    localparam int HB = 2;
    localparam int HT = 16;
    localparam int VD = 4;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int VT = 10;
    localparam int SK = 1;
    localparam int LF = 2;
    localparam int A  = HS + HB + SK;
    localparam int B  = VS + VB;
    localparam int M_SEARCH = 0;
    localparam int M_TRAIN  = 1;
    localparam int M_LOCK   = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        p_tick = 1'b0;
    logic        hsync = 1'b1;
    logic        vsync = 1'b1;
    logic [2:0]  rgb = 3'd0;
    logic        pix_valid;
    logic [10:0] pixel_x;
    logic [10:0] pixel_y;
    logic [2:0]  pix_rgb;
    logic        frame_start;
    logic        locked;
    logic        timing_err;
    logic [10:0] h_total_meas;
    logic [10:0] v_total_meas;

    vga_capture #(
        .H_DISPLAY(HD), .H_SYNC(HS), .H_BACK(HB), .H_TOTAL(HT),
        .V_DISPLAY(VD), .V_SYNC(VS), .V_BACK(VB), .V_TOTAL(VT),
        .RGB_SKEW(SK), .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .reset(reset), .p_tick(p_tick),
        .hsync(hsync), .vsync(vsync), .rgb(rgb),
        .pix_valid(pix_valid), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .pix_rgb(pix_rgb), .frame_start(frame_start), .locked(locked),
        .timing_err(timing_err), .h_total_meas(h_total_meas),
        .v_total_meas(v_total_meas)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: ticks are timestamped; line length is the distance
    // between hsync falls, line number is the count of falls since vsync.
    int   t;
    int   anchor;
    int   lines;
    int   mode;
    int   good;
    bit   m_seen;
    bit   m_err;
    bit   m_fbad;
    bit   m_hprev;
    bit   m_vprev;
    int   e_hmeas;
    int   e_vmeas;
    int   e_x;
    int   e_y;
    bit   e_valid;
    bit   e_fs;
    logic [2:0] e_rgb;

    bit xpat;
    int strobes;
    int first_x;
    int first_y;
    int last_x;
    int last_y;

    typedef struct {
        int lines;
        int stretch;
        int hmeas;
        int vmeas;
        bit lock;
        bit err;
    } row_t;

    row_t tbl[11];
    row_t rel[3];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        t = 0; anchor = 0; lines = 0; mode = M_SEARCH; good = 0;
        m_seen = 0; m_err = 0; m_fbad = 0; m_hprev = 0; m_vprev = 0;
        e_hmeas = 0; e_vmeas = 0; e_valid = 0; e_fs = 0;
    endtask

    task automatic model_tick(input bit hs, input bit vs, input logic [2:0] c);
        bit hf;
        bit vf;
        bit hbad;
        bit ok;
        int age;
        int vm;
        int hpos;
        int mode0;
        mode0 = mode;
        hf = m_hprev && !hs;
        vf = m_vprev && !vs;
        m_hprev = hs;
        m_vprev = vs;
        t++;
        age = t - anchor;
        hbad = 0;
        vm = 0;
        if (hf) begin
            if (m_seen) begin
                e_hmeas = age;
                hbad = (age != HT);
            end
            m_seen = 1;
            anchor = t;
        end
        if (vf) begin
            vm = lines + int'(hf);
            e_vmeas = vm;
            lines = 0;
        end else if (hf) begin
            lines++;
        end
        hpos = hf ? 0 : (age > 2047 ? 2047 : age);
        e_fs = vf;
        e_valid = (mode0 == M_LOCK) && hpos >= A && hpos <= A + HD - 1 &&
                  lines >= B && lines <= B + VD - 1;
        if (e_valid) begin
            e_x = hpos - A;
            e_y = lines - B;
            e_rgb = c;
        end
        if (hbad) m_err = 1;
        if (vf) begin
            ok = (vm == VT) && !m_fbad && !hbad;
            if (mode0 != M_SEARCH && vm != VT) m_err = 1;
            if (mode0 == M_SEARCH) begin
                mode = M_TRAIN;
                good = 0;
            end else if (mode0 == M_TRAIN) begin
                good = ok ? good + 1 : 0;
                if (good == LF) mode = M_LOCK;
            end else if (!ok) begin
                mode = M_TRAIN;
                good = 0;
            end
            m_fbad = 0;
        end else if (hbad) begin
            m_fbad = 1;
            if (mode == M_LOCK) begin
                mode = M_TRAIN;
                good = 0;
            end
        end
        if (!hf && age >= 2047) begin
            mode = M_SEARCH;
            m_seen = 0;
            m_err = 1;
            good = 0;
        end
    endtask

    task automatic do_tick(input bit hs, input bit vs, input logic [2:0] c);
        int idle;
        idle = $urandom_range(0, 2);
        for (int k = 0; k < idle; k++) begin
            p_tick = 1'b0;
            @(posedge clk);
            #1;
            chk("idle_strobes", 32'({pix_valid, frame_start}), 32'd0);
        end
        p_tick = 1'b1;
        hsync = hs;
        vsync = vs;
        rgb = c;
        @(posedge clk);
        #1;
        p_tick = 1'b0;
        model_tick(hs, vs, c);
        chk("pix_valid", 32'(pix_valid), 32'(e_valid));
        chk("frame_start", 32'(frame_start), 32'(e_fs));
        chk("locked", 32'(locked), 32'(mode == M_LOCK));
        chk("timing_err", 32'(timing_err), 32'(m_err));
        chk("h_total_meas", 32'(h_total_meas), e_hmeas);
        chk("v_total_meas", 32'(v_total_meas), e_vmeas);
        if (e_valid) begin
            chk("pixel_x", 32'(pixel_x), e_x);
            chk("pixel_y", 32'(pixel_y), e_y);
            chk("pix_rgb", 32'(pix_rgb), 32'(e_rgb));
        end
        if (pix_valid) begin
            if (xpat) chk("rgb_is_x", 32'(pix_rgb), 32'(pixel_x[2:0]));
            if (strobes == 0) begin
                first_x = int'(pixel_x);
                first_y = int'(pixel_y);
            end
            last_x = int'(pixel_x);
            last_y = int'(pixel_y);
            strobes++;
        end
    endtask

    function automatic logic [2:0] colour(input int hc);
        if (xpat) return 3'(hc - A);
        return 3'($urandom_range(0, 7));
    endfunction

    task automatic ticks(input bit vlow, input int from, input int to);
        for (int hc = from; hc <= to; hc++)
            do_tick(hc >= HS, !vlow, colour(hc));
    endtask

    task automatic play_lines(input int from, input int to);
        for (int l = from; l <= to; l++)
            ticks(l < VS, 0, HT - 1);
    endtask

    task automatic play_frame(input row_t r);
        for (int l = 0; l < r.lines; l++) begin
            int len;
            len = (l == r.stretch) ? HT + 1 : HT;
            ticks(l < VS, 0, 0);
            if (l == 0) begin
                chk("row_h_meas", 32'(h_total_meas), r.hmeas);
                chk("row_v_meas", 32'(v_total_meas), r.vmeas);
                chk("row_locked", 32'(locked), 32'(r.lock));
                chk("row_err", 32'(timing_err), 32'(r.err));
                strobes = 0;
            end
            if (r.stretch >= 0 && l == r.stretch + 1) begin
                chk("stretch_h_meas", 32'(h_total_meas), HT + 1);
                chk("stretch_unlock", 32'(locked), 32'd0);
                chk("stretch_err", 32'(timing_err), 32'd1);
            end
            ticks(l < VS, 1, len - 1);
        end
        if (r.lock && r.stretch < 0) begin
            chk("strobe_count", strobes, HD * VD);
            chk("first_xy", (first_x << 16) | first_y, 0);
            chk("last_xy", (last_x << 16) | last_y, ((HD - 1) << 16) | (VD - 1));
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        p_tick = 1'b1;
        hsync = 1'($urandom_range(0, 1));
        vsync = 1'($urandom_range(0, 1));
        repeat (n) @(posedge clk);
        #1;
        chk("rst_pix_valid", 32'(pix_valid), 32'd0);
        chk("rst_pixel_x", 32'(pixel_x), 32'd0);
        chk("rst_pixel_y", 32'(pixel_y), 32'd0);
        chk("rst_pix_rgb", 32'(pix_rgb), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_timing_err", 32'(timing_err), 32'd0);
        chk("rst_h_meas", 32'(h_total_meas), 32'd0);
        chk("rst_v_meas", 32'(v_total_meas), 32'd0);
        reset = 1'b1;
        p_tick = 1'b0;
        model_reset();
    endtask

    initial begin
        // lines, stretched line, h_meas, v_meas, locked, err at frame open
        tbl[0]  = '{10, -1,  0,  1, 1'b0, 1'b0};
        tbl[1]  = '{10, -1, 16, 10, 1'b0, 1'b0};
        tbl[2]  = '{10, -1, 16, 10, 1'b1, 1'b0};
        tbl[3]  = '{10,  5, 16, 10, 1'b1, 1'b0};
        tbl[4]  = '{10, -1, 16, 10, 1'b0, 1'b1};
        tbl[5]  = '{10, -1, 16, 10, 1'b0, 1'b1};
        tbl[6]  = '{11, -1, 16, 10, 1'b1, 1'b1};
        tbl[7]  = '{10, -1, 16, 11, 1'b0, 1'b1};
        tbl[8]  = '{10, -1, 16, 10, 1'b0, 1'b1};
        tbl[9]  = '{10, -1, 16, 10, 1'b1, 1'b1};
        tbl[10] = '{10, -1, 16, 10, 1'b1, 1'b1};
        rel[0]  = '{10, -1, 16,  5, 1'b0, 1'b0};
        rel[1]  = '{10, -1, 16, 10, 1'b0, 1'b0};
        rel[2]  = '{10, -1, 16, 10, 1'b1, 1'b0};
        xpat = 0;
        strobes = 0;
        model_reset();
        do_reset(3);
        repeat (4) do_tick(1'b1, 1'b1, 3'd0);
        for (int i = 0; i < 11; i++) begin
            xpat = (i >= 8);
            play_frame(tbl[i]);
        end
        xpat = 0;
        play_lines(0, 4);
        do_reset(3);
        play_lines(5, 9);
        for (int i = 0; i < 3; i++)
            play_frame(rel[i]);
        // Hold hsync high long enough for the line counter to saturate.
        for (int k = 0; k < 2048; k++)
            do_tick(1'b1, 1'b1, 3'($urandom_range(0, 7)));
        chk("loss_locked", 32'(locked), 32'd0);
        chk("loss_err", 32'(timing_err), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
